// File: rtl/keypad_pkg.sv
// Shared types, key map and frame decode
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef logic [15:0] frame_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } result_t;

  localparam result_t RESULT_NONE = '{vld: 1'b0, code: 4'h0};

  // Entry index is {column, row}; bit i of a frame maps to KEY_MAP[i].
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  function automatic result_t frame_decode(frame_t f);
    result_t    r;
    logic [4:0] n;
    r = RESULT_NONE;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      if (f[i]) begin
        n      = n + 5'd1;
        r.code = KEY_MAP[i];
      end
    end
    // Ghosting and empty frames both collapse to NONE.
    if (n != 5'd1) begin
      r = RESULT_NONE;
    end else begin
      r.vld = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-result debounce and key acceptance:
// saturating repeat count, key / key_down / key_valid.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_done_i,
  input  result_t    result_i,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  output logic       key_down_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CONE = CW'(1);

  result_t       prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          down_q, down_d;
  logic          vld_q, vld_d;
  logic          same;
  logic          reach;

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    key_d  = key_q;
    down_d = down_q;
    vld_d  = 1'b0;
    same   = 1'b0;
    reach  = 1'b0;
    if (frame_done_i) begin
      same = (result_i == prev_q);
      if (same) begin
        cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + CONE;
      end else begin
        prev_d = result_i;
        cnt_d  = CONE;
      end
      // Act only on the frame where the count first hits the target.
      reach = (cnt_d == CMAX) && !(same && cnt_q == CMAX);
      if (reach) begin
        if (result_i.vld) begin
          if (!down_q || result_i.code != key_q) begin
            key_d  = result_i.code;
            down_d = 1'b1;
            vld_d  = 1'b1;
          end
        end else begin
          down_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      prev_q <= RESULT_NONE;
      cnt_q  <= '0;
      key_q  <= 4'h0;
      down_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      key_q  <= key_d;
      down_q <= down_d;
      vld_q  <= vld_d;
    end
  end

  assign key_o       = key_q;
  assign key_valid_o = vld_q;
  assign key_down_o  = down_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row sync, column strobe,
// frame latch and one-hot decode feeding the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE   = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = $clog2(SETTLE);
  localparam logic [DW-1:0] LAST = DW'(SETTLE - 1);
  localparam logic [DW-1:0] DONE = DW'(1);

  logic [3:0]    s1_q, s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [3:0]    col_q, col_d;
  frame_t        frame_q, frame_d;
  logic          done_q, done_d;
  result_t       result;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q <= 4'b1111;
      s2_q <= 4'b1111;
    end else begin
      s1_q <= row;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    dwell_d = dwell_q + DONE;
    cidx_d  = cidx_q;
    col_d   = col_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    if (dwell_q == LAST) begin
      dwell_d = '0;
      cidx_d  = cidx_q + 2'd1;
      col_d   = {col_q[2:0], col_q[3]};
      // Rows are active-low; frame bits are 1 for pressed.
      frame_d[{cidx_q, 2'b00} +: 4] = ~s2_q;
      done_d  = (cidx_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      dwell_q <= '0;
      cidx_q  <= 2'd0;
      col_q   <= 4'b1110;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      cidx_q  <= cidx_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign result = frame_decode(frame_q);
  assign col    = col_q;

  keypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb (
    .clk         (clk),
    .clr         (clr),
    .frame_done_i(done_q),
    .result_i    (result),
    .key_o       (key),
    .key_valid_o (key_valid),
    .key_down_o  (key_down)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a
// behavioural keypad model (SETTLE=4, DEBOUNCE=3).
module tb_keypad_scanner;

  logic       clk;
  logic       clr;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;

  logic       k0_en, k1_en;
  logic [3:0] k0, k1;
  int         nchk, nerr;
  int         npulse, ndbl;
  logic       kv_prev;

  keypad_scanner #(
    .SETTLE  (4),
    .DEBOUNCE(3)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {column, row} position of each key on the pad.
  function automatic logic [3:0] pos(input logic [3:0] k);
    case (k)
      4'h1: pos = {2'd0, 2'd0};
      4'h4: pos = {2'd0, 2'd1};
      4'h7: pos = {2'd0, 2'd2};
      4'h0: pos = {2'd0, 2'd3};
      4'h2: pos = {2'd1, 2'd0};
      4'h5: pos = {2'd1, 2'd1};
      4'h8: pos = {2'd1, 2'd2};
      4'hF: pos = {2'd1, 2'd3};
      4'h3: pos = {2'd2, 2'd0};
      4'h6: pos = {2'd2, 2'd1};
      4'h9: pos = {2'd2, 2'd2};
      4'hE: pos = {2'd2, 2'd3};
      4'hA: pos = {2'd3, 2'd0};
      4'hB: pos = {2'd3, 2'd1};
      4'hC: pos = {2'd3, 2'd2};
      default: pos = {2'd3, 2'd3};
    endcase
  endfunction

  always_comb begin
    logic [3:0] p0, p1;
    row = 4'b1111;
    p0  = pos(k0);
    p1  = pos(k1);
    if (k0_en && !col[p0[3:2]]) row[p0[1:0]] = 1'b0;
    if (k1_en && !col[p1[3:2]]) row[p1[1:0]] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid) npulse <= npulse + 1;
    if (key_valid && kv_prev) ndbl <= ndbl + 1;
    kv_prev <= key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nchk = 0; nerr = 0;
    npulse = 0; ndbl = 0; kv_prev = 1'b0;
    k0_en = 1'b0; k1_en = 1'b0;
    k0 = 4'h0; k1 = 4'h0;
    clr = 1'b1;
    step(3);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_kv", key_valid, 1'b0);
    check("rst_kd", key_down, 1'b0);
    clr = 1'b0;
    step(4);  check("col1", col, 4'b1101);
    step(4);  check("col2", col, 4'b1011);
    step(4);  check("col3", col, 4'b0111);
    step(4);  check("col0", col, 4'b1110);

    // Press '5' at a frame boundary (edge 16).
    k0 = 4'h5; k0_en = 1'b1;
    step(48); check("p5_pre_kv", key_valid, 1'b0);
    check("p5_pre_kd", key_down, 1'b0);
    step(1);  check("p5_kv", key_valid, 1'b1);
    check("p5_key", key, 4'h5);
    check("p5_kd", key_down, 1'b1);
    step(1);  check("p5_kv_low", key_valid, 1'b0);
    step(46); check("p5_pulses", npulse, 1);
    check("p5_hold_kd", key_down, 1'b1);

    // Release '5' (edge 112).
    k0_en = 1'b0;
    step(48); check("r5_kd_hold", key_down, 1'b1);
    step(1);  check("r5_kd", key_down, 1'b0);
    check("r5_key", key, 4'h5);
    check("r5_pulses", npulse, 1);
    step(15);

    // Bouncing 'A' then stable (edge 176).
    k0 = 4'hA;
    for (int i = 0; i < 4; i++) begin
      k0_en = (i % 2 == 0);
      step(16);
    end
    k0_en = 1'b1;
    step(48); check("bA_pre_kv", key_valid, 1'b0);
    check("bA_pulses", npulse, 1);
    step(1);  check("bA_kv", key_valid, 1'b1);
    check("bA_key", key, 4'hA);
    check("bA_kd", key_down, 1'b1);
    step(15);

    // Release 'A' (edge 304), then ghost '1'+'D'.
    k0_en = 1'b0;
    step(49); check("rA_kd", key_down, 1'b0);
    step(15);
    k0 = 4'h1; k1 = 4'hD;
    k0_en = 1'b1; k1_en = 1'b1;
    step(48); check("gh_kd_mid", key_down, 1'b0);
    step(48); check("gh_kd", key_down, 1'b0);
    check("gh_pulses", npulse, 2);
    check("gh_key", key, 4'hA);

    // Hold '8' and reset mid-frame (edge 464).
    k1_en = 1'b0;
    k0 = 4'h8;
    step(32);
    step(6);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("mr_col", col, 4'b1110);
    check("mr_key", key, 4'h0);
    check("mr_kv", key_valid, 1'b0);
    check("mr_kd", key_down, 1'b0);
    step(48); check("mr_pre_kv", key_valid, 1'b0);
    check("mr_pre_key", key, 4'h0);
    step(1);  check("p8_kv", key_valid, 1'b1);
    check("p8_key", key, 4'h8);
    check("p8_kd", key_down, 1'b1);
    step(2);  check("tot_pulses", npulse, 3);
    check("no_double_kv", ndbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
